// File: rtl/sar_rx_pkg.sv
// sar_rx_pkg: shared types and constants for the SAR data receiver.
//   - rx_state_t : receive FSM states
//   - BEAT_W / WORD_W : ADC bus beat width and assembled word width
//   - offset_to_twos() : offset-binary to two's-complement conversion
package sar_rx_pkg;

    localparam int BEAT_W = 6;
    localparam int WORD_W = 12;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LO = 1'b1
    } rx_state_t;

    // Offset binary maps to two's complement by flipping the sign bit.
    function automatic logic [WORD_W-1:0] offset_to_twos(input logic [WORD_W-1:0] w);
        return {~w[WORD_W-1], w[WORD_W-2:0]};
    endfunction

endpackage

// File: rtl/sar_data_receiver_if.sv
// sar_data_receiver_if: one-deep valid/ready word stream.
//   word_o       : assembled 12-bit conversion result
//   word_valid_o : word_o holds an unconsumed word
//   word_ready_i : consumer accepts word_o this cycle
//   master = receiver side, slave = downstream consumer side.
interface sar_data_receiver_if;
    import sar_rx_pkg::*;

    logic [WORD_W-1:0] word_o;
    logic              word_valid_o;
    logic              word_ready_i;

    modport master (output word_o, output word_valid_o, input word_ready_i);
    modport slave  (input word_o, input word_valid_o, output word_ready_i);
endinterface

// File: rtl/sar_rx_sync.sv
// sar_rx_sync: N-stage single-bit synchroniser with rising-edge detector.
//   clk, rst_z : core clock, synchronous active-low reset
//   d          : asynchronous input
//   rise       : one-cycle pulse when the synchronised input goes 0 -> 1
module sar_rx_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_z,
    input  logic d,
    output logic rise
);
    // sr[N-1:0] is the synchroniser chain, sr[N] the edge-detect history flop.
    logic [N:0] sr;

    always_ff @(posedge clk) begin
        if (!rst_z) sr <= '0;
        else        sr <= {sr[N-1:0], d};
    end

    assign rise = sr[N-1] & ~sr[N];
endmodule

// File: rtl/sar_data_receiver.sv
// sar_data_receiver: reassembles 12-bit SAR words from two 6-bit beats.
//   clk, rst_z    : core clock, synchronous active-low reset
//   en            : receiver enable; low aborts a partial word
//   data_in       : 6-bit beat bus (high half first, then low half)
//   clk_data_in   : asynchronous beat strobe
//   twos_comp     : 1 = present words as two's complement
//   word_if       : valid/ready output stream (one-deep register)
//   overflow_o    : sticky, a completed word was dropped
//   timeout_o     : sticky, low beat did not arrive in time
//   clr_flags_i   : clears both sticky flags (a same-cycle set wins)
//   word_count_o  : words accepted into the output register, wraps
module sar_data_receiver
    import sar_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_z,
    input  logic                 en,
    input  logic [BEAT_W-1:0]    data_in,
    input  logic                 clk_data_in,
    input  logic                 twos_comp,
    sar_data_receiver_if.master  word_if,
    output logic                 overflow_o,
    output logic                 timeout_o,
    input  logic                 clr_flags_i,
    output logic [CNT_W-1:0]     word_count_o
);
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Strobe and data share the stage count so the beat is aligned with
    // the data it qualifies.
    logic beat;
    sar_rx_sync #(.N(SYNC_STAGES)) u_strobe_sync (
        .clk  (clk),
        .rst_z(rst_z),
        .d    (clk_data_in),
        .rise (beat)
    );

    logic [SYNC_STAGES-1:0][BEAT_W-1:0] data_sync;
    always_ff @(posedge clk) begin
        if (!rst_z) data_sync <= '0;
        else        data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
    end
    wire [BEAT_W-1:0] data_s = data_sync[SYNC_STAGES-1];

    // Receive FSM; deliver_q/timeout_q are registered one-cycle events.
    rx_state_t         state;
    logic [BEAT_W-1:0] hi_q;
    logic [TO_W-1:0]   to_cnt;
    logic [WORD_W-1:0] asm_q;
    logic              deliver_q;
    logic              timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_z) begin
            state     <= IDLE;
            hi_q      <= '0;
            to_cnt    <= '0;
            asm_q     <= '0;
            deliver_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            deliver_q <= 1'b0;
            timeout_q <= 1'b0;
            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (beat) begin
                        hi_q   <= data_s;
                        to_cnt <= '0;
                        state  <= WAIT_LO;
                    end
                    WAIT_LO: if (beat) begin
                        asm_q     <= twos_comp ? offset_to_twos({hi_q, data_s})
                                               : {hi_q, data_s};
                        deliver_q <= 1'b1;
                        state     <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // One-deep output register with sticky flags.
    logic [WORD_W-1:0] word_q;
    logic              valid_q;
    logic              ovf_set;

    assign ovf_set = deliver_q & valid_q & ~word_if.word_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_z) begin
            word_q       <= '0;
            valid_q      <= 1'b0;
            overflow_o   <= 1'b0;
            timeout_o    <= 1'b0;
            word_count_o <= '0;
        end else begin
            if (deliver_q && (!valid_q || word_if.word_ready_i)) begin
                word_q       <= asm_q;
                valid_q      <= 1'b1;
                word_count_o <= word_count_o + CNT_W'(1);
            end else if (valid_q && word_if.word_ready_i) begin
                valid_q <= 1'b0;
            end
            overflow_o <= ovf_set   | (overflow_o & ~clr_flags_i);
            timeout_o  <= timeout_q | (timeout_o  & ~clr_flags_i);
        end
    end

    assign word_if.word_o       = word_q;
    assign word_if.word_valid_o = valid_q;
endmodule

// File: doc/sar_data_receiver.md
Name: sar_data_receiver

Overview:
Reader side of the SAR state machine's 6-bit parallel output bus (data, clk_data) on the digital core clock. Synchronises the clk_data strobe, captures two 6-bit beats per conversion and reassembles each 12-bit ADC word. Presents words on a valid/ready interface to downstream logic (decimator, register bank), with overflow and missing-beat detection.

Parameters:
SYNC_STAGES, 2, flip-flop stages on clk_data_in and data_in before edge detection (min 2).
TIMEOUT_CYCLES, 64, max clk cycles between high beat and low beat before the partial word is discarded.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  input  1  core clock
rst_z  input  1  reset, synchronous, active-low
en  input  1  receiver enable; low aborts any partial word
data_in  input  6  ADC data beat, stable around the clk_data rising edge
clk_data_in  input  1  beat strobe from ADC state machine, asynchronous to clk
twos_comp  input  1  1: output signed (MSB inverted); 0: offset binary as received
word_o  output  12  assembled conversion result
word_valid_o  output  1  word_o holds an unconsumed word
word_ready_i  input  1  downstream accepts word_o when high with word_valid_o
overflow_o  output  1  sticky: a completed word was dropped (output full)
timeout_o  output  1  sticky: low beat missing within TIMEOUT_CYCLES
clr_flags_i  input  1  clears overflow_o and timeout_o
word_count_o  output  CNT_W  number of words accepted into the output register, wraps

Behaviour:
- Reset is synchronous, active-low, single clock clk. On rst_z=0 at a clk edge: word_o=0, word_valid_o=0, overflow_o=0, timeout_o=0, word_count_o=0, FSM=IDLE, sync/edge flops=0, timeout counter=0.
- Sync: clk_data_in and data_in each pass through SYNC_STAGES flops, plus one further flop on the strobe. Beat event = last sync stage high and extra flop low. Data is taken from the last data sync stage in the same cycle as the beat event.
- Beat order per conversion: first beat = word bits [11:6], second beat = bits [5:0].
- FSM states:
  - IDLE: beat event -> store high half, clear timeout counter, go WAIT_LO.
  - WAIT_LO, beat event -> assemble {hi,lo}; if twos_comp, invert bit 11; deliver; go IDLE.
  - WAIT_LO, counter reaches TIMEOUT_CYCLES-1 with no beat -> discard high half, set timeout_o, go IDLE.
- en=0: FSM forced to IDLE, partial word discarded, beats ignored. Output register, flags and counter are held; the handshake still works.
- Latency (SYNC_STAGES=2): word_valid_o rises at the 3rd clk edge after the edge that first samples the second clk_data_in high.
- Output register, one deep. Deliver succeeds if word_valid_o=0, or word_ready_i=1 in the same cycle. Simultaneous consume and deliver: new word loaded, valid stays 1, no overflow.
- Deliver with word_valid_o=1 and word_ready_i=0: new word dropped, old word_o kept, overflow_o set. The counter is not incremented.
- Successful deliver increments word_count_o (mod 2^CNT_W).
- Consume without deliver: word_valid_o=0 next cycle. word_o is held.
- clr_flags_i clears both flags. If a set event occurs in the same cycle, set wins.
- Reset mid-word: partial word discarded. The strobe edge flop resets to 0, so a clk_data_in held high through reset release produces one beat event.
- Minimum supported strobe high and low time: SYNC_STAGES+1 clk cycles.

Decomposition:
- Package sar_rx_pkg:
  - FSM state enum (IDLE, WAIT_LO)
  - BEAT_W=6, WORD_W=12 constants
  - function for the offset-binary to two's-complement conversion
- Sub-module sar_rx_sync: parameterised N-stage synchroniser plus rising-edge detector, instanced for the strobe. The data bus uses the same stage count without edge detect.

Test Plan:
- Reset then beats 0x2A, 0x15, twos_comp=0, ready=1 -> word_o=0xA95, valid for 1 cycle, word_count_o=1.
- Same beats, twos_comp=1 -> word_o=0x295. Beats 0x20, 0x00 -> 0x000 signed.
- ready=0, three full conversions (0x001, 0x002, 0x003) -> word_o stays 0x001, overflow_o=1, count=1. Then clr_flags_i -> overflow_o=0.
- High beat 0x3F only, no second strobe for 64 cycles -> timeout_o=1, valid stays 0. Next conversion 0x01, 0x02 -> word_o=0x042.
- ready=1 held, a word is pending, second conversion completes in the same cycle it is consumed -> valid stays 1, new word shown, no overflow.
- en dropped after first beat, raised, then full conversion 0x10, 0x03 -> only 0x403 delivered. rst_z pulsed mid-word -> all outputs 0.
